// File: rtl/wb_arbiter2.sv
// Two-master to one-slave pipelined Wishbone arbiter with round-robin grant per bus cycle.
// Tracks outstanding requests so responses return to the issuing master; abort drops s_cyc at once.
module wb_arbiter2 #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_wdat,
  input  logic [3:0]  m0_sel,
  output logic [31:0] m0_rdat,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_stall,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_wdat,
  input  logic [3:0]  m1_sel,
  output logic [31:0] m1_rdat,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_stall,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_wdat,
  output logic [3:0]  s_sel,
  input  logic [31:0] s_rdat,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic        s_stall
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cyc_g, full, cnt_nz, accept, resp, ack_fwd, err_fwd;

  assign cyc_g   = ((state == GNT0) && m0_cyc) || ((state == GNT1) && m1_cyc);
  assign full    = (cnt == CNT_MAX);
  assign cnt_nz  = (cnt != '0);
  assign accept  = s_stb && !s_stall;
  // Responses with nothing outstanding are slave protocol violations and are dropped.
  assign resp    = cyc_g && cnt_nz && (s_ack || s_err);
  assign ack_fwd = cyc_g && cnt_nz && s_ack;
  assign err_fwd = cyc_g && cnt_nz && s_err;
  assign m0_rdat = s_rdat;
  assign m1_rdat = s_rdat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state_nxt == GNT0)
        last_grant <= 1'b0;
      else if (state_nxt == GNT1)
        last_grant <= 1'b1;
    end
  end

  // Grant is held for the whole Wishbone cycle; hand-over skips IDLE when the other master waits.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc)
          state_nxt = last_grant ? GNT0 : GNT1;
        else if (m0_cyc)
          state_nxt = GNT0;
        else if (m1_cyc)
          state_nxt = GNT1;
      end
      GNT0: if (!m0_cyc) state_nxt = m1_cyc ? GNT1 : IDLE;
      GNT1: if (!m1_cyc) state_nxt = m0_cyc ? GNT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (!cyc_g)
      cnt_nxt = '0;
    else if (accept && !resp)
      cnt_nxt = cnt + 1'b1;
    else if (resp && !accept)
      cnt_nxt = cnt - 1'b1;
  end

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_wdat   = '0;
    s_sel    = '0;
    m0_stall = 1'b1;
    m1_stall = 1'b1;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_err   = 1'b0;
    m1_err   = 1'b0;
    case (state)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_cyc && m0_stb && !full;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_wdat   = m0_wdat;
        s_sel    = m0_sel;
        m0_stall = s_stall || full;
        m0_ack   = ack_fwd;
        m0_err   = err_fwd;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_cyc && m1_stb && !full;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_wdat   = m1_wdat;
        s_sel    = m1_sel;
        m1_stall = s_stall || full;
        m1_ack   = ack_fwd;
        m1_err   = err_fwd;
      end
      default: ;
    endcase
  end
endmodule
